// File: rtl/captura_operandos.sv
// Operand-entry sequencer: button sync/debounce/press detect feeding a 4-step A/B/op/show FSM.
// Optional debouncer selected by `CAPTURA_DEBOUNCE_EN; when undefined the synchronised level is used directly.
module captura_operandos #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic [3:0] sw_dado,
    input  logic [1:0] sw_op,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [1:0] seletor,
    output logic       valido,
    output logic       carga_pulso,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    state_t state;
    logic   sync1;
    logic   sync2;
    logic   stable;
    logic   stable_d;
    logic   press;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

`ifdef CAPTURA_DEBOUNCE_EN
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // New level accepted only after it persists DEBOUNCE_CYCLES edges; any bounce restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync2 != stable) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^DEBOUNCE_CYCLES;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b1;
        end else begin
            stable <= sync2;
        end
    end
`endif

    // One-cycle pulse on the debounced 1->0 transition only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

    // Entry FSM with registered data, valid flag and load strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_A;
            a           <= '0;
            b           <= '0;
            seletor     <= '0;
            valido      <= 1'b0;
            carga_pulso <= 1'b0;
        end else begin
            carga_pulso <= 1'b0;
            if (press) begin
                case (state)
                    S_A: begin
                        a     <= sw_dado;
                        state <= S_B;
                    end
                    S_B: begin
                        b     <= sw_dado;
                        state <= S_OP;
                    end
                    S_OP: begin
                        seletor     <= sw_op;
                        valido      <= 1'b1;
                        carga_pulso <= 1'b1;
                        state       <= S_SHOW;
                    end
                    S_SHOW: begin
                        valido <= 1'b0;
                        state  <= S_A;
                    end
                endcase
            end
        end
    end

    assign estado = state;

endmodule

// File: doc/captura_operandos.md
# captura_operandos

Upstream operand-entry sequencer for the 4-bit ULA board top.
- Lets the user enter operand A, operand B and the operation selector one at a time on the same switches, each step committed by a push-button press.
- Presents registered, stable `a`, `b` and `seletor` to the ALU datapath, plus a valid flag and the current step for the LEDs.
- Contains the button synchroniser, debouncer, press detector and a 4-state entry FSM.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive clk cycles a new button level must persist before it is accepted (10 ms at 50 MHz); minimum 1.

Ports:
- `clk`  input  1  system clock; every register is clocked on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `btn_n`  input  1  push-button, active-low, asynchronous to `clk`, bouncy.
- `sw_dado`  input  4  data switches, sampled when A or B is committed.
- `sw_op`  input  2  operation switches, sampled when the selector is committed (00 soma, 01 sub, 10 AND, 11 OR).
- `a`  output  4  committed operand A, registered.
- `b`  output  4  committed operand B, registered.
- `seletor`  output  2  committed operation selector, registered.
- `valido`  output  1  high while all three values form a complete committed set.
- `carga_pulso`  output  1  one-cycle strobe marking the cycle the set becomes complete.
- `estado`  output  2  current FSM state code, for LEDs.

## Operation

Button path:
- Two-flop synchroniser on `btn_n`; both flops reset to 1.
- Debouncer holds a `stable` level (reset 1) and a counter (reset 0).
  - Each edge, if sync output ≠ `stable`: if counter == `DEBOUNCE_CYCLES`−1, then `stable` ← sync and counter ← 0; otherwise counter increments.
  - If sync output == `stable`, counter ← 0, so any bounce restarts the count.
  - Counter width is sized for `DEBOUNCE_CYCLES`−1; it never wraps.
- Press detector registers `press` = previous `stable` AND NOT `stable`.
  - `press` is a one-cycle pulse on the 1→0 transition only.
  - Release, and holding the button down, generate no further pulses.

FSM (`estado` encoding):
- `S_A` (00): on `press`, `a` ← `sw_dado`; go to `S_B`.
- `S_B` (01): on `press`, `b` ← `sw_dado`; go to `S_OP`.
- `S_OP` (10): on `press`, `seletor` ← `sw_op`; go to `S_SHOW`; `carga_pulso` = 1 for that one cycle.
- `S_SHOW` (11): `valido` = 1. On `press`, go to `S_A` and drop `valido`.
- Without `press`, every state holds.

Register behaviour:
- `a`, `b` and `seletor` change only at their own commit.
- When the FSM returns to `S_A`, they keep their old values until overwritten.
- Switch changes outside a commit edge have no effect.

Reset values (`rst_n` low at an edge):
- `a` = 0, `b` = 0, `seletor` = 00, `valido` = 0, `carga_pulso` = 0, `estado` = 00.
- Synchroniser flops = 1, `stable` = 1, counter = 0, `press` = 0.
- Reset has priority over everything, including a `press` in the same cycle.
- Reset mid-sequence discards any partial entry.

## Timing

With `btn_n` low from edge k onward, no bounce:
- Sync output is low after edge k+1.
- `stable` falls at edge k+1+`DEBOUNCE_CYCLES`.
- `press` is high during the cycle after edge k+2+`DEBOUNCE_CYCLES`.
- The FSM, data registers, `valido` and `carga_pulso` update at edge k+3+`DEBOUNCE_CYCLES`.
- `carga_pulso` is high for exactly the cycle following that edge.

Other timing rules:
- A low pulse shorter than `DEBOUNCE_CYCLES` cycles at the sync output produces no `press`.
- The button must be released (debounced) before the next press can register, so two commits are at least 2×`DEBOUNCE_CYCLES` apart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `CAPTURA_DEBOUNCE_EN` defined: debouncer present exactly as specified above.
- Not defined:
  - The debouncer is removed; `stable` ← sync output every cycle.
  - `DEBOUNCE_CYCLES` is ignored.
  - Timing equals the `DEBOUNCE_CYCLES` = 1 case: update at edge k+4.
  - Intended for fast simulation and for clean, pre-debounced button sources.

## Test plan

Benches use `DEBOUNCE_CYCLES` = 4 with `CAPTURA_DEBOUNCE_EN` defined unless stated.
- **Reset:** hold `rst_n` = 0 for 3 edges with `btn_n` toggling → `a`=0, `b`=0, `seletor`=00, `valido`=0, `carga_pulso`=0, `estado`=00 throughout.
- **Full entry:** 3 clean presses of 10 cycles each (released 10 cycles between), with `sw_dado`=0101, then `sw_dado`=0011, then `sw_op`=01 → `a`=0101, `b`=0011, `seletor`=01, `estado`=11, `valido`=1; `carga_pulso` high exactly one cycle, 7 edges after the third `btn_n` fall; a 4th press → `estado`=00, `valido`=0, `a`/`b`/`seletor` unchanged.
- **Bounce rejection:** `btn_n` low for 2 cycles, high for 1, repeated 5×, then high → no state change; then low for 10 cycles → exactly one advance.
- **Long hold:** `btn_n` low for 200 cycles → single advance `S_A`→`S_B`; release generates no advance.
- **Reset mid-entry:** in `S_OP` with `a`=1111, `b`=1000, pulse `rst_n` low for 1 edge coincident with a `press` → `estado`=00, all outputs 0, no `carga_pulso`.
- **Macro off:** recompile without `CAPTURA_DEBOUNCE_EN`; `btn_n` low at edge k → `estado` changes at edge k+4; a 1-cycle glitch → one advance.
